// File: rtl/exc_pkg.sv
// ============================================================================
// Module   : exc_pkg
// Brief    : Shared ExcCodes, cm_exc bit indices and sequencer encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_NONE = 5'h1f;

    localparam int EB_ADEL_IF = 6;
    localparam int EB_RI      = 5;
    localparam int EB_OV      = 4;
    localparam int EB_SYS     = 3;
    localparam int EB_BP      = 2;
    localparam int EB_ADEL_LS = 1;
    localparam int EB_ADES    = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

endpackage

`default_nettype wire

// File: rtl/exc_ctrl_if.sv
// ============================================================================
// Module   : exc_ctrl_if
// Brief    : Commit, CP0 and redirect signals around the exception controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface exc_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                cm_valid;
    logic [PC_WIDTH-1:0] cm_pc;
    logic                cm_bd;
    logic [6:0]          cm_exc;
    logic                cm_eret;
    logic [PC_WIDTH-1:0] cm_vaddr;
    logic                cm_ready;
    logic [31:0]         status;
    logic [31:0]         cause;
    logic [PC_WIDTH-1:0] epc;
    logic                trap;
    logic                eret;
    logic [4:0]          excode;
    logic                exc_bd;
    logic                epc_wen;
    logic [PC_WIDTH-1:0] epc_wdata;
    logic                bva_wen;
    logic [PC_WIDTH-1:0] bva_wdata;
    logic                flush;
    logic                redir_valid;
    logic [PC_WIDTH-1:0] redir_pc;
    logic                redir_ready;

    // Pipeline/CP0 side
    modport master (
        output cm_valid, cm_pc, cm_bd, cm_exc, cm_eret, cm_vaddr,
        output status, cause, epc, redir_ready,
        input  cm_ready, trap, eret, excode, exc_bd, epc_wen, epc_wdata,
        input  bva_wen, bva_wdata, flush, redir_valid, redir_pc
    );

    // Exception controller side
    modport slave (
        input  cm_valid, cm_pc, cm_bd, cm_exc, cm_eret, cm_vaddr,
        input  status, cause, epc, redir_ready,
        output cm_ready, trap, eret, excode, exc_bd, epc_wen, epc_wdata,
        output bva_wen, bva_wdata, flush, redir_valid, redir_pc
    );
endinterface

`default_nettype wire

// File: rtl/exc_prio.sv
// ============================================================================
// Module   : exc_prio
// Brief    : Combinational priority pick among interrupt, exception flags, ERET.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exc_prio
    import exc_pkg::*;
(
    input  wire logic [6:0] cm_exc_i,
    input  wire logic       int_pend_i,
    input  wire logic       cm_eret_i,
    output logic            hit_o,
    output logic            is_eret_o,
    output logic [4:0]      excode_o,
    output logic            use_vaddr_o
);

    always_comb begin
        hit_o       = int_pend_i | (|cm_exc_i) | cm_eret_i;
        is_eret_o   = cm_eret_i & ~int_pend_i & ~(|cm_exc_i);
        excode_o    = EXC_INT;
        use_vaddr_o = 1'b0;
        if (int_pend_i) begin
            excode_o = EXC_INT;
        end else if (cm_exc_i[EB_ADEL_IF]) begin
            excode_o = EXC_ADEL;
        end else if (cm_exc_i[EB_RI]) begin
            excode_o = EXC_RI;
        end else if (cm_exc_i[EB_OV]) begin
            excode_o = EXC_OV;
        end else if (cm_exc_i[EB_SYS]) begin
            excode_o = EXC_SYS;
        end else if (cm_exc_i[EB_BP]) begin
            excode_o = EXC_BP;
        end else if (cm_exc_i[EB_ADEL_LS]) begin
            excode_o    = EXC_ADEL;
            use_vaddr_o = 1'b1;
        end else if (cm_exc_i[EB_ADES]) begin
            excode_o    = EXC_ADES;
            use_vaddr_o = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module   : exc_ctrl
// Brief    : Commit-point exception arbiter; drives CP0 pulses, flush, redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exc_ctrl
    import exc_pkg::*;
#(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(EXC_VECTOR_DEFAULT)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    exc_ctrl_if.slave   bus
);

    logic [1:0]          state_q, state_d;
    logic [4:0]          excode_q;
    logic                is_eret_q, bd_q, exl_q, bva_q, use_vaddr_q;
    logic [PC_WIDTH-1:0] pc_q, vaddr_q, epc_q;

    logic                w_int_pend, w_hit, w_is_eret, w_use_vaddr, w_take;
    logic [4:0]          w_excode;
    logic                w_unused;

    assign w_int_pend = bus.status[0] & ~bus.status[1]
                      & (|(bus.status[15:8] & bus.cause[15:8]));
    assign w_unused   = ^{bus.status[31:16], bus.status[7:2],
                          bus.cause[31:16], bus.cause[7:0]};

    exc_prio u_prio (
        .cm_exc_i    (bus.cm_exc),
        .int_pend_i  (w_int_pend),
        .cm_eret_i   (bus.cm_eret),
        .hit_o       (w_hit),
        .is_eret_o   (w_is_eret),
        .excode_o    (w_excode),
        .use_vaddr_o (w_use_vaddr)
    );

    assign w_take = (state_q == S_IDLE) & bus.cm_valid & w_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_take) state_d = S_FLUSH;
            S_FLUSH: state_d = S_REDIR;
            S_REDIR: if (bus.redir_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            excode_q    <= EXC_NONE;
            is_eret_q   <= 1'b0;
            bd_q        <= 1'b0;
            exl_q       <= 1'b0;
            bva_q       <= 1'b0;
            use_vaddr_q <= 1'b0;
            pc_q        <= '0;
            vaddr_q     <= '0;
            epc_q       <= '0;
        end else begin
            state_q <= state_d;
            if (w_take) begin
                is_eret_q   <= w_is_eret;
                bd_q        <= bus.cm_bd;
                exl_q       <= bus.status[1];
                bva_q       <= ~w_is_eret & ~w_int_pend
                             & ((w_excode == EXC_ADEL) | (w_excode == EXC_ADES));
                use_vaddr_q <= w_use_vaddr;
                pc_q        <= bus.cm_pc;
                vaddr_q     <= bus.cm_vaddr;
                epc_q       <= bus.epc;
                // ExcCode is sticky across ERETs so Cause keeps the last trap cause
                if (!w_is_eret) excode_q <= w_excode;
            end
        end
    end

    assign bus.cm_ready    = (state_q == S_IDLE);
    assign bus.flush       = (state_q == S_FLUSH);
    assign bus.trap        = (state_q == S_FLUSH) & ~is_eret_q;
    assign bus.eret        = (state_q == S_FLUSH) &  is_eret_q;
    assign bus.excode      = excode_q;
    assign bus.exc_bd      = bus.trap & bd_q;
    assign bus.epc_wen     = bus.trap & ~exl_q;
    assign bus.epc_wdata   = bd_q ? (pc_q - PC_WIDTH'(4)) : pc_q;
    assign bus.bva_wen     = bus.trap & bva_q;
    assign bus.bva_wdata   = use_vaddr_q ? vaddr_q : pc_q;
    assign bus.redir_valid = (state_q == S_REDIR);
    assign bus.redir_pc    = (state_q != S_REDIR) ? '0
                           : (is_eret_q ? epc_q : EXC_VECTOR);

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt arbiter directly upstream of the CP0 register file.
- Samples the instruction at the commit point, prioritises its exception flags against pending interrupts, and drives CP0 with trap/eret pulses, ExcCode, EPC and BadVAddr.
- Runs a 3-state sequencer that flushes the pipeline and hands a redirect PC (handler vector, or EPC on eret) to fetch.

Parameters:
- EXC_VECTOR, 32'hbfc00380, handler entry PC (BEV=1).
- PC_WIDTH, 32, width of all PC/address buses.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cm_valid  in  1  commit-stage instruction valid.
- cm_pc  in  PC_WIDTH  PC of the committing instruction.
- cm_bd  in  1  committing instruction sits in a delay slot.
- cm_exc  in  7  flags {adel_if, ri, ov, sys, bp, adel_ls, ades}, bit6 = adel_if.
- cm_eret  in  1  committing instruction is ERET.
- cm_vaddr  in  PC_WIDTH  load/store virtual address.
- cm_ready  out  1  commit accepted; high only in IDLE.
- status  in  32  CP0 Status value.
- cause  in  32  CP0 Cause value.
- epc  in  PC_WIDTH  CP0 EPC value.
- trap  out  1  one-cycle pulse to CP0 (sets EXL).
- eret  out  1  one-cycle pulse to CP0 (clears EXL).
- excode  out  5  ExcCode for Cause.
- exc_bd  out  1  BD bit for Cause.
- epc_wen  out  1  write EPC this cycle.
- epc_wdata  out  PC_WIDTH  EPC write data.
- bva_wen  out  1  write BadVAddr this cycle.
- bva_wdata  out  PC_WIDTH  BadVAddr write data.
- flush  out  1  kill all younger pipeline stages.
- redir_valid  out  1  redirect PC valid.
- redir_pc  out  PC_WIDTH  target PC.
- redir_ready  in  1  fetch accepts redirect.

Behaviour:
- Reset: state IDLE. All outputs 0, except cm_ready=1 and excode=5'h1f. Reset mid-sequence aborts to IDLE; no pulse may be emitted afterwards.
- int_pend = status[0] & ~status[1] & |(status[15:8] & cause[15:8]).
- An event is taken in IDLE when cm_valid=1 and any of: int_pend, |cm_exc, cm_eret. Otherwise IDLE holds and all pulses stay 0.
- Priority, high to low, with ExcCode:
  - Int 0
  - AdEL-if 4
  - RI 10
  - Ov 12
  - Sys 8
  - Bp 9
  - AdEL-ls 4
  - AdES 5
  - ERET (no ExcCode).
- Any exception or interrupt overrides a simultaneous cm_eret.
- Capture cycle T (IDLE, event taken):
  - Register the winner, cm_pc, cm_bd and cm_vaddr.
  - Go to FLUSH.
- FLUSH (cycle T+1, exactly one cycle):
  - flush=1.
  - Exception: trap=1, excode=winner, exc_bd=cm_bd.
  - epc_wen=1 only if status[1] (EXL) was 0 at T. epc_wdata = cm_bd ? cm_pc-4 : cm_pc.
  - bva_wen=1 for AdEL-if (bva_wdata=cm_pc) or AdEL-ls/AdES (bva_wdata=cm_vaddr).
  - ERET: eret=1, trap=0, no CP0 writes.
  - Next state: REDIR.
- REDIR:
  - redir_valid=1. redir_pc=EXC_VECTOR for exceptions, or epc sampled at T for ERET.
  - Held stable until redir_ready=1. Return to IDLE in the cycle after the handshake.
- cm_ready=0 in FLUSH and REDIR; commits are back-pressured.
- Minimum latency capture→redirect: 2 cycles.
- redir_ready high in the same cycle redir_valid rises counts as an immediate handshake.
- excode holds its last value between events.
- PC arithmetic is modulo 2^PC_WIDTH.

Decomposition:
- Shared package exc_pkg holds:
  - ExcCode constants EXC_INT/ADEL/ADES/SYS/BP/RI/OV.
  - cm_exc bit-index constants.
  - State encoding IDLE/FLUSH/REDIR.
  - EXC_VECTOR default.
- One combinational sub-module, exc_prio: cm_exc + int_pend + cm_eret → {hit, is_eret, excode, use_vaddr}.
- Sequencer and capture registers live in exc_ctrl.

Test Plan:
- Ov at cm_pc=0x80001000, bd=0, EXL=0 → T+1: trap=1, excode=12, epc_wen=1, epc_wdata=0x80001000, flush=1. T+2: redir_pc=0xbfc00380.
- Sys in delay slot, pc=0x80002004, bd=1 → epc_wdata=0x80002000, exc_bd=1, excode=8.
- AdES with vaddr=0x80003001 → excode=5, bva_wen=1, bva_wdata=0x80003001. Same case with EXL=1 → epc_wen=0, trap=1.
- status=0x00000401, cause=0x00000400, cm_valid=1, concurrent ri=1 → excode=0 (interrupt wins). Same with status[1]=1 → excode=10.
- ERET with epc=0x80004000 → eret=1, trap=0, redir_pc=0x80004000. Hold redir_ready=0 for 3 cycles → redir_valid held, cm_ready=0. Returns to IDLE the cycle after the handshake.
- Assert rst while in REDIR → next cycle: redir_valid=0, cm_ready=1, excode=5'h1f, no trap/eret pulse.
